vec_mem_sequencer: RTL
======================

Name: vec_mem_sequencer

Overview:
- Arbitrates one single-port, byte-wide data memory between two requesters: pipeline writeback/memory stage (pipe) and host loader (host).
- Serializes each granted vector load/store into vecSize per-lane scalar memory accesses, then returns the assembled vector.
- Sits between the writeback stage's memory request path and the scalar data memory array.

Parameters:
- vecSize, 4, lanes per vector transaction
- registerSize, 8, lane width and address width in bits

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pipe_req  in  1  pipeline request, level, held until pipe_done
- pipe_we  in  1  1 = store, 0 = load
- pipe_addr  in  registerSize  base address of lane 0
- pipe_wdata  in  vecSize x registerSize  store data, lane i = element i
- pipe_gnt  out  1  pipeline owns memory (ACCESS through DONE)
- pipe_done  out  1  one-cycle completion pulse
- host_req, host_we, host_addr, host_wdata  in  same as pipe_*  host request
- host_gnt, host_done  out  1  same as pipe_*
- rdata  out  vecSize x registerSize  assembled load result, shared
- busy  out  1  state != IDLE
- mem_we  out  1  scalar memory write strobe
- mem_addr  out  registerSize  scalar memory address
- mem_wdata  out  registerSize  scalar write data
- mem_rdata  in  registerSize  scalar read data, valid one cycle after address

Behaviour:
- Reset (reset low, async): state IDLE, lane counter 0, all gnt/done/busy/mem_we 0, mem_addr/mem_wdata 0, rdata all-zero. A store in flight is abandoned; lanes already written stay written.
- States: IDLE, ACCESS, DRAIN, DONE.
- IDLE: sample requests. If any is high, choose a winner, latch its we/addr/wdata, clear the lane counter and go to ACCESS. Otherwise stay in IDLE. Requests are sampled only in IDLE.
- Default arbitration: pipe beats host when both are high.
- ACCESS, lane k from 0 to vecSize-1:
  - mem_addr = (base + k) mod 2^registerSize, so addresses wrap past the top of memory.
  - mem_we = latched we.
  - mem_wdata = wdata[k].
  - For a load with k >= 1, capture mem_rdata into rdata[k-1].
  - At k = vecSize-1: a store goes to DONE; a load goes to DRAIN.
- DRAIN (loads only): mem_we 0; capture mem_rdata into rdata[vecSize-1]; go to DONE.
- DONE: assert the winner's done for exactly one cycle, then go to IDLE.
- Store transactions leave rdata unchanged. rdata holds until overwritten by the next load.
- Memory outputs are combinational decodes of registered state only. mem_we = 0 and mem_addr = 0 outside ACCESS.
- gnt is high for the winner from the first ACCESS cycle through DONE inclusive. pipe_gnt and host_gnt are never high together.
- Latency, request seen in IDLE at cycle t:
  - store: done at t + vecSize + 1
  - load: done at t + vecSize + 2
- Requester rule: drop req in the cycle after it sees done. If req is still high in IDLE, it starts a new transaction.
- Request inputs changing during ACCESS, DRAIN or DONE are ignored; the latched copies are used.

Optional Feature:
- Macro: VEC_MEM_SEQ_ROUND_ROBIN_EN.
- Defined: a 1-bit last-winner register, reset value = host. When both requesters are high in IDLE, the one that did not win last is granted. A single requester is always granted.
- Undefined: fixed priority, pipe always wins. Host can starve under continuous pipe traffic.

Test Plan:
- Pipe store, addr 0x10, wdata {0x44,0x33,0x22,0x11} (lane3..0):
  - mem writes 0x11@0x10, 0x22@0x11, 0x33@0x12, 0x44@0x13 on consecutive cycles.
  - pipe_done 5 cycles after the IDLE sample.
  - rdata unchanged.
- Host load, addr 0x10, after the above: rdata = {0x44,0x33,0x22,0x11}; host_done 6 cycles after the sample; pipe_gnt stays 0.
- Wrap: pipe store at addr 0xFE with vecSize 4 → mem_addr sequence 0xFE, 0xFF, 0x00, 0x01.
- Contention, both req high in the same IDLE cycle:
  - Default build: pipe served first, host served in the next transaction.
  - With VEC_MEM_SEQ_ROUND_ROBIN_EN and 3 back-to-back contended transactions: winners pipe, host, pipe.
- Reset mid-store: assert reset low during lane 2 of ACCESS.
  - Immediately: busy = 0, mem_we = 0, gnt = 0, rdata = 0.
  - Lanes 0–1 are written; lanes 2–3 are not.
  - After release with no requests: stays in IDLE.
- Held req: pipe keeps req high through DONE into IDLE → a second identical transaction starts. Bench checks two pipe_done pulses.

Source files
------------

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: arbitrates one byte-wide memory between pipe and host, serializing vector load/store into per-lane accesses (VEC_MEM_SEQ_ROUND_ROBIN_EN selects round-robin arbitration)
module vec_mem_sequencer #(
  parameter int vecSize = 4,
  parameter int registerSize = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  pipe_req,
  input  logic                                  pipe_we,
  input  logic [registerSize-1:0]               pipe_addr,
  input  logic [vecSize-1:0][registerSize-1:0]  pipe_wdata,
  output logic                                  pipe_gnt,
  output logic                                  pipe_done,
  input  logic                                  host_req,
  input  logic                                  host_we,
  input  logic [registerSize-1:0]               host_addr,
  input  logic [vecSize-1:0][registerSize-1:0]  host_wdata,
  output logic                                  host_gnt,
  output logic                                  host_done,
  output logic [vecSize-1:0][registerSize-1:0]  rdata,
  output logic                                  busy,
  output logic                                  mem_we,
  output logic [registerSize-1:0]               mem_addr,
  output logic [registerSize-1:0]               mem_wdata,
  input  logic [registerSize-1:0]               mem_rdata
);
  localparam int LW = vecSize > 1 ? $clog2(vecSize) : 1;
  localparam logic [LW-1:0] LAST_LANE = LW'(vecSize - 1);
  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] lane_q, lane_d;
  logic we_q, we_d, host_q, host_d, pick_host, acc;
  logic [registerSize-1:0] addr_q, addr_d;
  logic [vecSize-1:0][registerSize-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
`ifdef VEC_MEM_SEQ_ROUND_ROBIN_EN
  logic last_q, last_d;
  assign pick_host = host_req & (~pipe_req | ~last_q);
  assign last_d = (state_q == IDLE && (pipe_req || host_req)) ? pick_host : last_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) last_q <= 1'b1;
    else last_q <= last_d;
`else
  assign pick_host = host_req & ~pipe_req;
`endif
  always_comb begin
    state_d = state_q;
    lane_d = lane_q;
    we_d = we_q;
    host_d = host_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (pipe_req || host_req) begin
        state_d = ACCESS;
        lane_d = '0;
        host_d = pick_host;
        we_d = pick_host ? host_we : pipe_we;
        addr_d = pick_host ? host_addr : pipe_addr;
        wdata_d = pick_host ? host_wdata : pipe_wdata;
      end
      ACCESS: begin
        if (!we_q && lane_q != '0) rdata_d[lane_q - LW'(1)] = mem_rdata;
        if (lane_q == LAST_LANE) state_d = we_q ? DONE : DRAIN;
        else lane_d = lane_q + LW'(1);
      end
      DRAIN: begin
        rdata_d[vecSize-1] = mem_rdata;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      lane_q <= '0;
      we_q <= 1'b0;
      host_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      lane_q <= lane_d;
      we_q <= we_d;
      host_q <= host_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  assign acc = state_q == ACCESS;
  assign mem_we = acc & we_q;
  assign mem_addr = acc ? addr_q + registerSize'(lane_q) : '0;
  assign mem_wdata = acc ? wdata_q[lane_q] : '0;
  assign busy = state_q != IDLE;
  assign pipe_gnt = busy & ~host_q;
  assign host_gnt = busy & host_q;
  assign pipe_done = (state_q == DONE) & ~host_q;
  assign host_done = (state_q == DONE) & host_q;
  assign rdata = rdata_q;
endmodule
